// File: rtl/regfile_writeback.sv
// Write-back arbiter for the single register-file write port: ALU results win,
// load results wait in a small in-order queue and drain when the port is idle.
module regfile_writeback #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_dest,
    input  logic [31:0]              alu_data,
    input  logic                     ld_valid,
    input  logic [4:0]               ld_dest,
    input  logic [31:0]              ld_data,
    output logic                     ld_ready,
    input  logic [4:0]               query_reg,
    output logic                     query_pending,
    output logic [$clog2(DEPTH):0]   ld_count,
    output logic [4:0]               write_reg,
    output logic [31:0]              data,
    output logic                     reg_write_flag
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] q_live;
    logic [4:0]       q_dest [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             alu_win;
    logic             ld_push;
    logic             q_pop;
    logic [DEPTH-1:0] occupied;
    logic             queue_hit;

    // Load handshake: a load transfers on a rising edge where ld_valid && ld_ready;
    // ld_ready depends only on the registered count, never on ld_valid or the pop.
    always_comb begin
        alu_win  = alu_valid && (alu_dest != 5'd0);
        ld_ready = (count != CNT_W'(DEPTH));
        ld_push  = ld_valid && ld_ready && (ld_dest != 5'd0);
        q_pop    = !alu_win && (count != '0);
    end

    assign ld_count = count;

    // An entry is occupied when its distance from the read pointer is below the count.
    always_comb begin
        occupied  = '0;
        queue_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            occupied[i] = ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr)} < count);
            if (occupied[i] && q_live[i] && (q_dest[i] == query_reg))
                queue_hit = 1'b1;
        end
    end

    always_comb begin
        query_pending = 1'b0;
        if (query_reg != 5'd0)
            query_pending = queue_hit || (reg_write_flag && (write_reg == query_reg));
    end

    // Queue storage. The squash loop runs before the push so that a load accepted
    // alongside an ALU write to the same register stays live (it is the younger write).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_live <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_dest[i] <= '0;
                q_data[i] <= '0;
            end
        end else begin
            if (alu_win) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (q_dest[i] == alu_dest)
                        q_live[i] <= 1'b0;
                end
            end
            if (q_pop) begin
                q_live[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + 1'b1;
            end
            if (ld_push) begin
                q_live[wr_ptr] <= 1'b1;
                q_dest[wr_ptr] <= ld_dest;
                q_data[wr_ptr] <= ld_data;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            count <= count + CNT_W'(ld_push) - CNT_W'(q_pop);
        end
    end

    // Output stage: a dead head still consumes its pop cycle with the write enable low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_flag <= 1'b0;
            write_reg      <= '0;
            data           <= '0;
        end else if (alu_win) begin
            reg_write_flag <= 1'b1;
            write_reg      <= alu_dest;
            data           <= alu_data;
        end else if (q_pop) begin
            reg_write_flag <= q_live[rd_ptr];
            if (q_live[rd_ptr]) begin
                write_reg <= q_dest[rd_ptr];
                data      <= q_data[rd_ptr];
            end
        end else begin
            reg_write_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: hand-computed write sequences go into an
// expected queue that a negedge monitor consumes, plus cycle-exact spot checks.
module tb_regfile_writeback;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_dest;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_dest;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic [4:0]  query_reg;
    logic        query_pending;
    logic [2:0]  ld_count;
    logic [4:0]  write_reg;
    logic [31:0] data;
    logic        reg_write_flag;

    int n_vec = 0;
    int n_err = 0;
    logic [36:0] exp_q[$];

    regfile_writeback #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_data(ld_data),
        .ld_ready(ld_ready),
        .query_reg(query_reg), .query_pending(query_pending),
        .ld_count(ld_count),
        .write_reg(write_reg), .data(data), .reg_write_flag(reg_write_flag)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] d, input logic [31:0] x);
        alu_valid = v;
        alu_dest  = d;
        alu_data  = x;
    endtask

    task automatic drive_ld(input logic v, input logic [4:0] d, input logic [31:0] x);
        ld_valid = v;
        ld_dest  = d;
        ld_data  = x;
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] x);
        exp_q.push_back({r, x});
    endtask

    // scoreboard: every enabled write must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst && reg_write_flag) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 64'(reg_write_flag), 64'(1'b0));
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("wb_order", 64'({write_reg, data}), 64'(e));
            end
        end
    end

    initial begin
        int ld_idx;
        logic acc;
        rst = 1'b1;
        drive_alu(1'b0, 5'd0, 32'd0);
        drive_ld(1'b0, 5'd0, 32'd0);
        query_reg = 5'd5;
        tick();
        tick();
        check("rst_flag", 64'(reg_write_flag), 64'(0));
        check("rst_wreg", 64'(write_reg), 64'(0));
        check("rst_data", 64'(data), 64'(0));
        check("rst_count", 64'(ld_count), 64'(0));
        check("rst_ready", 64'(ld_ready), 64'(1));
        check("rst_pend", 64'(query_pending), 64'(0));
        rst = 1'b0;

        // ALU write then asynchronous reset mid-cycle
        drive_alu(1'b1, 5'd5, 32'h12345678);
        expect_wr(5'd5, 32'h12345678);
        tick();
        check("alu_flag", 64'(reg_write_flag), 64'(1));
        check("alu_wreg", 64'(write_reg), 64'(5));
        check("alu_data", 64'(data), 64'h12345678);
        check("alu_pend", 64'(query_pending), 64'(1));
        drive_alu(1'b0, 5'd0, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("arst_flag", 64'(reg_write_flag), 64'(0));
        check("arst_wreg", 64'(write_reg), 64'(0));
        check("arst_data", 64'(data), 64'(0));
        check("arst_ready", 64'(ld_ready), 64'(1));
        tick();
        rst = 1'b0;

        // register 0 suppression
        drive_alu(1'b1, 5'd0, 32'hFFFFFFFF);
        tick();
        check("r0_alu_flag", 64'(reg_write_flag), 64'(0));
        drive_alu(1'b0, 5'd0, 32'd0);
        drive_ld(1'b1, 5'd0, 32'h77);
        check("r0_ld_ready_pre", 64'(ld_ready), 64'(1));
        tick();
        drive_ld(1'b0, 5'd0, 32'd0);
        check("r0_ld_ready", 64'(ld_ready), 64'(1));
        check("r0_ld_count", 64'(ld_count), 64'(0));
        tick();
        check("r0_ld_flag", 64'(reg_write_flag), 64'(0));

        // fill under continuous ALU traffic, then drain
        ld_idx = 0;
        for (int k = 0; k < 6; k++) begin
            drive_alu(1'b1, 5'd1, 32'h100 + 32'(k));
            expect_wr(5'd1, 32'h100 + 32'(k));
            drive_ld(1'b1, 5'(8 + ld_idx), 32'hA0 + 32'(ld_idx));
            acc = ld_ready;
            tick();
            if (acc) ld_idx++;
            if (k == 3) begin
                check("fill_ready", 64'(ld_ready), 64'(0));
                check("fill_count", 64'(ld_count), 64'(4));
            end
        end
        for (int j = 0; j < 5; j++) expect_wr(5'(8 + j), 32'hA0 + 32'(j));
        check("fill_held_idx", 64'(ld_idx), 64'(4));
        check("fill_held_count", 64'(ld_count), 64'(4));
        check("fill_alu_wreg", 64'(write_reg), 64'(1));
        check("fill_alu_data", 64'(data), 64'h105);
        drive_alu(1'b0, 5'd0, 32'd0);
        check("fill_ready_lag", 64'(ld_ready), 64'(0));
        tick();
        check("drain_ready", 64'(ld_ready), 64'(1));
        check("drain_count", 64'(ld_count), 64'(3));
        check("drain_first", 64'(write_reg), 64'(8));
        tick();
        drive_ld(1'b0, 5'd0, 32'd0);
        check("drain_pushpop", 64'(ld_count), 64'(3));
        check("drain_second", 64'(write_reg), 64'(9));
        repeat (3) tick();
        check("drain_empty", 64'(ld_count), 64'(0));
        check("drain_last_reg", 64'(write_reg), 64'(12));
        check("drain_last_data", 64'(data), 64'hA4);
        tick();
        check("drain_idle", 64'(reg_write_flag), 64'(0));

        // squash of a queued load by a later ALU write
        query_reg = 5'd7;
        drive_ld(1'b1, 5'd7, 32'h55);
        tick();
        drive_ld(1'b0, 5'd0, 32'd0);
        check("sq_pend_queued", 64'(query_pending), 64'(1));
        check("sq_count", 64'(ld_count), 64'(1));
        drive_alu(1'b1, 5'd7, 32'hAA);
        expect_wr(5'd7, 32'hAA);
        tick();
        check("sq_pend_stage", 64'(query_pending), 64'(1));
        check("sq_count_dead", 64'(ld_count), 64'(1));
        drive_alu(1'b1, 5'd2, 32'h33);
        expect_wr(5'd2, 32'h33);
        tick();
        check("sq_pend_dead", 64'(query_pending), 64'(0));
        check("sq_dead_kept", 64'(ld_count), 64'(1));
        drive_alu(1'b0, 5'd0, 32'd0);
        tick();
        check("sq_dead_pop", 64'(reg_write_flag), 64'(0));
        check("sq_freed", 64'(ld_count), 64'(0));

        // load and ALU to the same register in the same cycle
        query_reg = 5'd3;
        drive_alu(1'b1, 5'd3, 32'h1);
        drive_ld(1'b1, 5'd3, 32'h2);
        expect_wr(5'd3, 32'h1);
        expect_wr(5'd3, 32'h2);
        tick();
        drive_alu(1'b0, 5'd0, 32'd0);
        drive_ld(1'b0, 5'd0, 32'd0);
        check("same_alu_data", 64'(data), 64'h1);
        check("same_count", 64'(ld_count), 64'(1));
        check("same_pend", 64'(query_pending), 64'(1));
        tick();
        check("same_ld_flag", 64'(reg_write_flag), 64'(1));
        check("same_ld_data", 64'(data), 64'h2);
        tick();
        check("same_pend_clear", 64'(query_pending), 64'(0));

        // continuous push/pop across several pointer wraps
        for (int k = 0; k < 10; k++) begin
            drive_ld(1'b1, 5'(16 + k), 32'hC0 + 32'(k));
            expect_wr(5'(16 + k), 32'hC0 + 32'(k));
            tick();
            check("wrap_count", 64'(ld_count), 64'(1));
        end
        drive_ld(1'b0, 5'd0, 32'd0);
        tick();
        check("wrap_empty", 64'(ld_count), 64'(0));
        check("wrap_last_reg", 64'(write_reg), 64'(25));
        check("wrap_last_data", 64'(data), 64'hC9);

        // reset while loads are queued discards them
        drive_alu(1'b1, 5'd1, 32'h200);
        expect_wr(5'd1, 32'h200);
        drive_ld(1'b1, 5'd9, 32'h300);
        tick();
        drive_alu(1'b1, 5'd1, 32'h201);
        expect_wr(5'd1, 32'h201);
        drive_ld(1'b1, 5'd10, 32'h301);
        tick();
        check("qrst_count_pre", 64'(ld_count), 64'(2));
        drive_alu(1'b0, 5'd0, 32'd0);
        drive_ld(1'b0, 5'd0, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("qrst_count", 64'(ld_count), 64'(0));
        check("qrst_flag", 64'(reg_write_flag), 64'(0));
        tick();
        rst = 1'b0;
        query_reg = 5'd9;
        check("qrst_pend", 64'(query_pending), 64'(0));
        repeat (2) tick();
        check("qrst_no_drain", 64'(reg_write_flag), 64'(0));

        repeat (2) tick();
        check("sb_drained", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-back arbiter and load-result queue driving the single write port of the 32×32 general-purpose register file. Two sources are merged onto that port. ALU/R-format results arrive every cycle and cannot stall. Load results arrive later from memory, are queued, and drain when the port is free. The block also keeps writes to register 0 off the port, squashes stale queued loads, and reports pending writes so control can stall dependent reads.

## Interface
- DEPTH, 4: load-queue entries; power of two, ≥2
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU result valid this cycle
- alu_dest  in  5  ALU destination register
- alu_data  in  32  ALU result
- ld_valid  in  1  load result offered
- ld_dest  in  5  load destination register
- ld_data  in  32  load data
- ld_ready  out  1  queue can accept; a load transfers when ld_valid && ld_ready
- query_reg  in  5  register number being read by decode
- query_pending  out  1  a write to query_reg is queued or in the output stage
- ld_count  out  log2(DEPTH)+1  occupied queue entries, including squashed entries
- write_reg  out  5  register-file write address
- data  out  32  register-file write data
- reg_write_flag  out  1  register-file write enable

## Operation
**Queue**
- Circular FIFO of DEPTH entries. Each entry holds {live, dest, data}.
- Read and write pointers wrap modulo DEPTH.
- ld_ready = (ld_count != DEPTH). It is combinational from the count only; there is no pop-through when full.
- Accepted load with ld_dest = 0: the handshake completes, nothing is enqueued.
- Accepted load with ld_dest ≠ 0: enqueued with live = 1.

**Output selection** (registered, evaluated each rising edge, in priority order)
1. alu_valid && alu_dest ≠ 0:
   - write_reg ← alu_dest, data ← alu_data, reg_write_flag ← 1.
   - Every queued entry with dest == alu_dest gets live ← 0 (squash).
2. Otherwise, if the queue is non-empty, pop the head:
   - Head live = 1: write_reg ← dest, data ← data, reg_write_flag ← 1.
   - Head live = 0: reg_write_flag ← 0 and the slot is freed. This consumes the cycle.
3. Otherwise reg_write_flag ← 0. write_reg and data hold their values.

**Ordering and simultaneous events**
- An ALU write with alu_dest = 0 is ignored entirely. The queue may pop in that cycle.
- A load accepted in the same cycle as an ALU write to the same dest is treated as younger. It is enqueued live and is not squashed.
- Push and pop in the same cycle: ld_count is unchanged. Accepting a load into a non-full queue is legal even while the queue is popping.
- The queue drains strictly in order. At most one pop per cycle.

**query_pending** (combinational)
- 1 when query_reg ≠ 0 and either of the following holds:
  - any occupied entry with live = 1 has dest == query_reg, or
  - reg_write_flag = 1 and write_reg == query_reg.
- 0 otherwise.

## Timing
- **Reset values:**
  - reg_write_flag = 0, write_reg = 0, data = 0.
  - ld_count = 0, both pointers = 0, all live = 0.
  - ld_ready = 1, query_pending = 0.
- **Reset mid-operation:** queue contents are discarded immediately (asynchronous). reg_write_flag drops to 0 in the same cycle, with no glitch to 1.
- **ALU latency:** input sampled at edge N, write port driven during cycle N+1. The register file commits at edge N+1.
- **Load latency:**
  - Into an empty queue with no ALU traffic: accepted at edge N, popped at edge N+1, committed at edge N+2.
  - Each cycle of ALU priority adds one cycle.
- **ld_ready:** updates in the cycle after the count changes. A full queue stays unready for one cycle after a pop frees a slot.
- **Throughput:** one register-file write per cycle maximum.
- **Starvation:** loads may wait indefinitely under continuous ALU traffic. Control is responsible for using ld_ready and query_pending.

## Test plan
- **ALU write, then reset:**
  - ALU 0x12345678→r5 at edge 1 → cycle 2: reg_write_flag = 1, write_reg = 5, data = 0x12345678.
  - Assert rst mid-cycle 2 → outputs zero immediately; ld_ready = 1.
- **Zero-register suppression:**
  - ALU 0xFFFFFFFF→r0 → reg_write_flag stays 0.
  - Load→r0 → ld_ready stays 1 and ld_count stays 0.
- **Queue fill and drain:**
  - Hold alu_valid (r1) for 6 cycles while offering loads 0xA0..0xA4→r8..r12.
  - After the 4th accept: ld_ready = 0, ld_count = 4, and the 5th load is held.
  - Release the ALU → writes r8..r12 appear in order, one per cycle. The 5th is accepted in the cycle after ld_ready returns.
- **Squash:**
  - Queue load 0x55→r7, then ALU 0xAA→r7 before the drain.
  - Entry is squashed and its pop shows reg_write_flag = 0. Register r7 ends at 0xAA.
  - query_pending(r7) = 1 while the ALU write is in the output stage; 0 once it commits and the dead entry remains.
- **Same-cycle load and ALU to the same dest:**
  - ALU 0x1→r3 and load 0x2→r3 in the same cycle.
  - Writes r3 = 0x1, then r3 = 0x2 in the next cycle.
- **Pointer wrap:**
  - Push and pop 10 loads continuously with DEPTH = 4 (simultaneous push/pop every cycle).
  - Data is written back in order, ld_count stays 1, and the pointers wrap cleanly.
